// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings and small decode helpers used by the decode/control block.
package mdu_pkg;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MTLO  = 3'd5;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_NONE  = 3'd7;

  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_PREP = 2'd1,
    MDU_S_CALC = 2'd2,
    MDU_S_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic mdu_is_mul(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

  // Mapping used by the control block for its ALU_MULT / ALU_DIV decodes.
  function automatic logic [MDU_OP_WIDTH-1:0] alu_to_mdu_op(input logic alu_mult,
                                                           input logic alu_div,
                                                           input logic is_unsigned);
    if (alu_mult)     return is_unsigned ? MDU_OP_MULTU : MDU_OP_MULT;
    else if (alu_div) return is_unsigned ? MDU_OP_DIVU  : MDU_OP_DIV;
    else              return MDU_OP_NONE;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One iteration of a restoring divide: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
// Relies on rem < divisor, so the DATA_W+1 bit difference's MSB is the borrow.
module mdu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              next_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // trial subtract; keep the difference only when there was no borrow
  always_comb begin
    shifted  = {rem, next_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[DATA_W];
    rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Build option: MDU_FAST_MULT_EN replaces the iterative multiply with a
// single-cycle combinational product; divide is unaffected.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO write here directly
// PREP  | take operand magnitudes, record signs, load counter
// CALC  | DATA_W shift-add (mul) or restoring-subtract (div) iterations
// FIX   | sign-correct the result, write HI/LO at the exit edge
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic [DATA_W-1:0]       op_a,
  input  logic [DATA_W-1:0]       op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       hi,
  output logic [DATA_W-1:0]       lo
);

  mdu_state_e state_q, state_d;
  logic       accept_iter;

  logic [CNT_W-1:0]        cnt_q;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic [DATA_W-1:0]       a_q, b_q;
  logic [DATA_W-1:0]       mcand_q;
  logic [DATA_W-1:0]       acc_hi_q, acc_lo_q;
  logic                    res_neg_q, rem_neg_q;
  logic [DATA_W-1:0]       hi_q, lo_q;
  logic                    done_q;

  logic                    op_q_mul, op_q_signed;
  logic [DATA_W-1:0]       mag_a, mag_b;
  logic [DATA_W:0]         mul_sum;
  logic [DATA_W-1:0]       div_rem_next;
  logic                    div_q_bit;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix, rem_fix;

  assign busy = (state_q != MDU_S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MDU_S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic and acceptance of iterative ops
  always_comb begin
    state_d     = state_q;
    accept_iter = 1'b0;
    case (state_q)
      MDU_S_IDLE: begin
`ifdef MDU_FAST_MULT_EN
        accept_iter = start && mdu_is_div(op);
`else
        accept_iter = start && (mdu_is_div(op) || mdu_is_mul(op));
`endif
        if (accept_iter) state_d = MDU_S_PREP;
      end
      MDU_S_PREP: state_d = MDU_S_CALC;
      MDU_S_CALC: if (cnt_q == CNT_W'(1)) state_d = MDU_S_FIX;
      MDU_S_FIX:  state_d = MDU_S_IDLE;
      default:    state_d = MDU_S_IDLE;
    endcase
  end

  // operand decode, magnitudes and per-iteration arithmetic
  always_comb begin
    op_q_mul    = mdu_is_mul(op_q);
    op_q_signed = mdu_is_signed(op_q);
    mag_a       = (op_q_signed && a_q[DATA_W-1]) ? (~a_q + 1'b1) : a_q;
    mag_b       = (op_q_signed && b_q[DATA_W-1]) ? (~b_q + 1'b1) : b_q;
    mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  end

  mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem      (acc_hi_q),
    .next_bit (acc_lo_q[DATA_W-1]),
    .divisor  (mcand_q),
    .rem_next (div_rem_next),
    .q_bit    (div_q_bit)
  );

  // two's-complement sign correction of the finished magnitudes
  always_comb begin
    prod_fix = {acc_hi_q, acc_lo_q};
    if (res_neg_q) prod_fix = ~prod_fix + 1'b1;
    quo_fix = res_neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    rem_fix = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
  end

  // working registers: latch operands, set up, then iterate
  // mul: acc_lo holds the multiplier, shifting product bits in from the top
  // div: acc_lo holds the dividend, shifting quotient bits in from the bottom
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= MDU_OP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        MDU_S_IDLE: begin
          if (accept_iter) begin
            op_q <= op;
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        MDU_S_PREP: begin
          res_neg_q <= op_q_signed && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          rem_neg_q <= op_q_signed && a_q[DATA_W-1];
          cnt_q     <= CNT_W'(DATA_W);
          acc_hi_q  <= '0;
          if (op_q_mul) begin
            acc_lo_q <= mag_b;
            mcand_q  <= mag_a;
          end else begin
            acc_lo_q <= mag_a;
            mcand_q  <= mag_b;
          end
        end
        MDU_S_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (op_q_mul) begin
            acc_hi_q <= mul_sum[DATA_W:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[DATA_W-1:1]};
          end else begin
            acc_hi_q <= div_rem_next;
            acc_lo_q <= {acc_lo_q[DATA_W-2:0], div_q_bit};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_a, fast_b, fast_prod;

  // single-cycle product, sign-extended to full width so MULT and MULTU share it
  always_comb begin
    fast_a    = {{DATA_W{(op == MDU_OP_MULT) && op_a[DATA_W-1]}}, op_a};
    fast_b    = {{DATA_W{(op == MDU_OP_MULT) && op_b[DATA_W-1]}}, op_b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // architectural HI/LO and the completion pulse
  // a zero divisor bypasses the arithmetic: HI keeps the raw dividend, LO all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == MDU_S_IDLE && start) begin
        case (op)
          MDU_OP_MTHI: hi_q <= op_a;
          MDU_OP_MTLO: lo_q <= op_a;
`ifdef MDU_FAST_MULT_EN
          MDU_OP_MULT, MDU_OP_MULTU: begin
            {hi_q, lo_q} <= fast_prod;
            done_q       <= 1'b1;
          end
`endif
          default: ;
        endcase
      end else if (state_q == MDU_S_FIX) begin
        done_q <= 1'b1;
        if (op_q_mul) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (b_q == '0) begin
          hi_q <= a_q;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (default build: iterative multiply).
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = MDU_OP_NONE;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one start cycle; returns at the negedge right after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = MDU_OP_NONE;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat, bcnt;
    issue(o, a, b);
    wait_done(lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd34);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, bcnt, done_seen;

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    rst = 1'b0;

    run_op("mult_neg2x3", MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // DIVU 100/7 with an MTLO attempted while busy
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op = MDU_OP_MTLO; op_a = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = MDU_OP_NONE;
    check("mtlo_busy_lo_held", lo, 32'hFFFF_FFFD);
    wait_done(lat, bcnt);
    check("divu_100_7_latency", 32'(lat), 32'd29);
    check("divu_100_7_hi", hi, 32'd2);
    check("divu_100_7_lo", lo, 32'd14);

    run_op("divu_by0", MDU_OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI while idle takes effect at the accepting edge
    issue(MDU_OP_MTHI, 32'h0000_A5A5, 32'h0);
    check("mthi_hi", hi, 32'h0000_A5A5);
    check("mthi_lo_kept", lo, 32'h8000_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("mthi_done_later", {31'd0, done}, 32'd0);

    // reset in the middle of CALC
    issue(MDU_OP_MULT, 32'd5, 32'd9);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("rst_mid_no_done", 32'(done_seen), 32'd0);
    check("rst_mid_lo_after", lo, 32'h0);

    run_op("mult_6x7", MDU_OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
